// File: rtl/ws2801_receiver.sv
// ws2801_receiver: deserialises WS2801 sClk/sIn into pixels and latched frames
module ws2801_receiver #(
  parameter int LEDS = 50,
  parameter int LATCH_CYCLES = 6250
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sClk,
  input  logic                       sIn,
  output logic                       pixel_v,
  output logic [23:0]                pixel_rgb,
  output logic [$clog2(LEDS)-1:0]    pixel_idx,
  output logic                       frame_done,
  output logic [$clog2(LEDS+1)-1:0]  frame_leds,
  output logic [24*LEDS-1:0]         rgb_frame,
  output logic                       overflow,
  output logic                       partial
);
  localparam int IW = $clog2(LEDS);
  localparam int CW = $clog2(LEDS+1);
  localparam int LW = $clog2(LATCH_CYCLES);
  typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, d1, d2, armed;
  logic [1:0] sync_fill;
  logic [23:0] sh, word;
  logic [4:0] bit_cnt;
  logic [CW-1:0] pix_cnt;
  logic ovf_work;
  logic [24*LEDS-1:0] wbuf;
  logic [LW-1:0] idle_cnt;
  logic sclk_edge, take, timeout;
  always_comb begin
    sclk_edge = s2 & ~s3 & armed;
    take = sclk_edge & (state != DONE);
    word = {sh[22:0], d2};
    timeout = (state == RECEIVE) & ~s2 & (idle_cnt == LW'(LATCH_CYCLES-1));
    state_nx = state == DONE ? IDLE : take ? RECEIVE : timeout ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {s1, s2, s3, d1, d2, armed} <= '0;
      sync_fill <= '0;
      sh <= '0;
      bit_cnt <= '0;
      pix_cnt <= '0;
      ovf_work <= 1'b0;
      wbuf <= '0;
      idle_cnt <= '0;
      pixel_v <= 1'b0;
      pixel_rgb <= '0;
      pixel_idx <= '0;
      frame_done <= 1'b0;
      frame_leds <= '0;
      rgb_frame <= '0;
      overflow <= 1'b0;
      partial <= 1'b0;
    end else begin
      state <= state_nx;
      s1 <= sClk;
      s2 <= s1;
      // s3 freezes in DONE so an edge landing there is still seen in IDLE
      s3 <= state == DONE ? s3 : s2;
      d1 <= sIn;
      d2 <= d1;
      // arm only once s2 carries real pin data, not the reset value
      sync_fill <= sync_fill == 2'd2 ? sync_fill : sync_fill + 2'd1;
      armed <= armed | ((sync_fill == 2'd2) & ~s2);
      pixel_v <= take && bit_cnt == 5'd23;
      frame_done <= state == DONE;
      idle_cnt <= (state != RECEIVE || take) ? '0 : s2 ? idle_cnt : idle_cnt + LW'(1);
      if (take) begin
        sh <= word;
        if (bit_cnt == 5'd23) begin
          bit_cnt <= '0;
          pixel_rgb <= word;
          pixel_idx <= pix_cnt < CW'(LEDS) ? IW'(pix_cnt) : IW'(LEDS-1);
          if (pix_cnt < CW'(LEDS)) begin
            wbuf[24*pix_cnt +: 24] <= word;
            pix_cnt <= pix_cnt + CW'(1);
          end else
            ovf_work <= 1'b1;
        end else
          bit_cnt <= bit_cnt + 5'd1;
      end
      if (state == DONE) begin
        rgb_frame <= wbuf;
        wbuf <= '0;
        frame_leds <= pix_cnt;
        overflow <= ovf_work;
        partial <= bit_cnt != 5'd0;
        pix_cnt <= '0;
        bit_cnt <= '0;
        ovf_work <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ws2801_receiver.sv
// tb_ws2801_receiver: frame-level table vectors plus reset/latch corner sequences
module tb_ws2801_receiver;
  localparam int LEDS = 50;
  localparam int LATCH = 6250;
  logic clk = 1'b0;
  logic rst, sclk, sin;
  logic pixel_v, frame_done, overflow, partial;
  logic [23:0] pixel_rgb;
  logic [$clog2(LEDS)-1:0] pixel_idx;
  logic [$clog2(LEDS+1)-1:0] frame_leds;
  logic [24*LEDS-1:0] rgb_frame;
  int n_cmp = 0, n_bad = 0, fd_cnt = 0, pv_cnt = 0;
  bit fbits[$];
  typedef struct {int npix; int xbits; int hp; int pat; int leds; bit ovf; bit part;} vec_t;
  vec_t tv[4];

  always #5 clk = ~clk;

  ws2801_receiver #(.LEDS(LEDS), .LATCH_CYCLES(LATCH)) dut (
    .clk(clk), .rst(rst), .sClk(sclk), .sIn(sin),
    .pixel_v(pixel_v), .pixel_rgb(pixel_rgb), .pixel_idx(pixel_idx),
    .frame_done(frame_done), .frame_leds(frame_leds), .rgb_frame(rgb_frame),
    .overflow(overflow), .partial(partial)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pixel k of the current frame: bits 24k..24k+23 as sent, first bit is MSB
  function automatic logic [23:0] px(int k);
    logic [23:0] r;
    r = '0;
    for (int j = 0; j < 24; j++) r = {r[22:0], fbits[24*k+j]};
    return r;
  endfunction

  always @(negedge clk) begin
    if (pixel_v) begin
      chk("pixel_idx", pixel_idx, pv_cnt < LEDS ? pv_cnt : LEDS-1);
      if (fbits.size() >= 24*(pv_cnt+1)) chk("pixel_rgb", pixel_rgb, px(pv_cnt));
      else chk("pixel_v_bits", fbits.size(), 24*(pv_cnt+1));
      pv_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic send_bit(bit b, int hp);
    sclk = 1'b0;
    sin = b;
    repeat (hp) tick;
    sclk = 1'b1;
    fbits.push_back(b);
    repeat (hp) tick;
  endtask

  task automatic send_px(logic [23:0] w, int hp);
    for (int j = 23; j >= 0; j--) send_bit(w[j], hp);
  endtask

  task automatic wait_fd(int prev, int budget);
    int i;
    i = 0;
    while (fd_cnt == prev && i < budget) begin
      tick;
      i++;
    end
    chk("frame_done_count", fd_cnt, prev + 1);
  endtask

  task automatic do_latch(int prev);
    sclk = 1'b0;
    repeat (LATCH) tick;
    wait_fd(prev, 50);
  endtask

  task automatic check_frame(int leds, bit ovf, bit part);
    logic [24*LEDS-1:0] ef;
    int n, bad;
    ef = '0;
    n = fbits.size() / 24;
    bad = -1;
    for (int k = 0; k < n && k < LEDS; k++) ef[24*k +: 24] = px(k);
    chk("frame_leds", frame_leds, leds);
    chk("overflow", overflow, ovf);
    chk("partial", partial, part);
    chk("pixel_count", pv_cnt, n);
    n_cmp++;
    if (rgb_frame !== ef) begin
      n_bad++;
      for (int k = 0; k < LEDS; k++) if (bad < 0 && rgb_frame[24*k +: 24] !== ef[24*k +: 24]) bad = k;
      $display("FAIL rgb_frame pixel %0d: got %06h expected %06h", bad, rgb_frame[24*bad +: 24], ef[24*bad +: 24]);
    end
    fbits.delete();
    pv_cnt = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rgb_frame"}, rgb_frame === '0, 1);
    chk({tag, "_frame_leds"}, frame_leds, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_partial"}, partial, 0);
    chk({tag, "_pixel_rgb"}, pixel_rgb, 0);
    chk({tag, "_pixel_idx"}, pixel_idx, 0);
    chk({tag, "_strobes"}, {pixel_v, frame_done}, 0);
  endtask

  initial begin
    int prev, n, xb, hp;
    logic [23:0] w;
    tv[0] = '{1, 0, 4, 2, 1, 1'b0, 1'b0};
    tv[1] = '{50, 0, 2, 0, 50, 1'b0, 1'b0};
    tv[2] = '{52, 0, 2, 0, 50, 1'b1, 1'b0};
    tv[3] = '{3, 7, 3, 1, 3, 1'b0, 1'b1};
    rst = 1'b1;
    sclk = 1'b0;
    sin = 1'b0;
    repeat (4) tick;
    rst = 1'b0;
    tick;
    chk_zero("reset");

    for (int i = 0; i < 4; i++) begin
      prev = fd_cnt;
      for (int p = 0; p < tv[i].npix; p++) begin
        w = tv[i].pat == 0 ? {8'(p), 8'hA5, ~8'(p)} : tv[i].pat == 2 ? 24'hFF8001 : 24'($urandom);
        send_px(w, tv[i].hp);
      end
      for (int b = 0; b < tv[i].xbits; b++) send_bit(1'($urandom), tv[i].hp);
      do_latch(prev);
      if (i == 1) chk("last_pixel", rgb_frame[24*49 +: 24], 24'h31A5CE);
      check_frame(tv[i].leds, tv[i].ovf, tv[i].part);
    end

    // random frame checked purely against the bit-queue model
    prev = fd_cnt;
    n = $urandom_range(6, 1);
    xb = $urandom_range(23, 0);
    hp = $urandom_range(5, 2);
    for (int p = 0; p < n; p++) send_px(24'($urandom), hp);
    for (int b = 0; b < xb; b++) send_bit(1'($urandom), hp);
    do_latch(prev);
    check_frame(n, 1'b0, xb != 0);

    // latch boundary: a 6249-cycle low run must not latch, 6250 must
    prev = fd_cnt;
    send_px(24'($urandom), 4);
    send_px(24'($urandom), 4);
    for (int b = 0; b < 5; b++) send_bit(1'($urandom), 4);
    sclk = 1'b0;
    repeat (LATCH - 1 - 4) tick;
    for (int b = 0; b < 10; b++) send_bit(1'($urandom), 4);
    chk("no_latch_6249", fd_cnt, prev);
    sclk = 1'b0;
    repeat (LATCH) tick;
    wait_fd(prev, 20);
    check_frame(2, 1'b0, 1'b1);

    // sClk high across reset release: first real edge is bit 0
    sclk = 1'b1;
    rst = 1'b1;
    repeat (3) tick;
    fbits.delete();
    pv_cnt = 0;
    rst = 1'b0;
    chk_zero("rst_high");
    repeat (5) tick;
    send_px(24'($urandom), 3);
    for (int b = 0; b < 6; b++) send_bit(1'($urandom), 3);
    chk("pix_before_rst", pv_cnt, 1);
    prev = fd_cnt;
    rst = 1'b1;
    repeat (2) tick;
    fbits.delete();
    pv_cnt = 0;
    sclk = 1'b0;
    rst = 1'b0;
    tick;
    chk_zero("rst_mid");
    chk("no_fd_on_rst", fd_cnt, prev);
    send_px(24'($urandom), 3);
    send_px(24'($urandom), 3);
    do_latch(prev);
    check_frame(2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ws2801_receiver.md
Name: ws2801_receiver

Overview:
- Receive-side counterpart of the WS2801 LED driver chain: samples the serial clock/data pair driven by the LED driver, deserialises 24-bit pixels and detects the >500 us latch gap.
- Publishes a per-pixel stream plus a latched full-frame image in the same flattened layout the driver consumes.
- Used on the DE1-SoC for loopback self-check (driver GPIO pins jumpered to receiver pins) and as a bench monitor for driver/visualiser tests.

Parameters:
- LEDS, 50, number of pixels captured per frame; pixels beyond this are dropped.
- LATCH_CYCLES, 6250, consecutive clk cycles of synced sClk low that constitute a latch (500 us at 12.5 MHz).

Ports:
- clk  input  1  system clock (12.5 MHz PLL output).
- rst  input  1  synchronous, active-high reset.
- sClk  input  1  asynchronous WS2801 serial clock from the pin.
- sIn  input  1  asynchronous WS2801 serial data from the pin.
- pixel_v  output  1  one-cycle pulse: pixel_rgb/pixel_idx valid.
- pixel_rgb  output  24  received pixel, {R[23:16], G[15:8], B[7:0]}.
- pixel_idx  output  $clog2(LEDS)  index of the pixel within the frame, 0 = first shifted.
- frame_done  output  1  one-cycle pulse on latch detection.
- frame_leds  output  $clog2(LEDS+1)  pixels captured in the last completed frame (saturates at LEDS).
- rgb_frame  output  24*LEDS  last completed frame; pixel i at [24*i +: 24].
- overflow  output  1  last completed frame held more than LEDS pixels.
- partial  output  1  last completed frame ended with a non-multiple-of-24 bit count.

Behaviour:
- Reset: all outputs 0, sync registers 0, state IDLE, armed = 0, all counters 0.
- Synchronisation:
  - sClk and sIn each pass through 2 flops (s1, s2); sClk has a third delay flop s3.
  - edge = s2 & ~s3 & armed.
  - armed sets on the first cycle with s2 == 0 after reset. This suppresses a false edge if sClk is high at reset release.
- Input timing: sClk high and low phases must each be at least 2 clk cycles. Behaviour for faster clocks is undefined.
- Sampling: on an edge cycle, synced sIn is shifted into a 24-bit register MSB-first, and bit_cnt (0..23) increments.
- Pixel completion (24th bit):
  - The following cycle: pixel_v = 1, pixel_rgb = the assembled word, pixel_idx = pix_cnt.
  - If pix_cnt < LEDS: write the pixel into the working buffer slot pix_cnt and increment pix_cnt. Otherwise set ovf_work and leave pix_cnt unchanged.
  - bit_cnt wraps to 0.
  - Latency: 3 clk edges from the first clk edge that sees sIn/sClk high at the pin to pixel_v high.
- FSM:
  - IDLE: idle_cnt held at 0. On edge, go to RECEIVE and process the bit.
  - RECEIVE:
    - idle_cnt clears on edge.
    - idle_cnt increments each cycle s2 == 0.
    - idle_cnt holds while s2 == 1, so a stuck-high clock never latches.
    - When idle_cnt reaches LATCH_CYCLES-1 with s2 == 0, go to DONE.
  - DONE (1 cycle):
    - frame_done = 1.
    - rgb_frame <= working buffer.
    - Working-buffer slots not written this frame are copied as 0.
    - frame_leds <= pix_cnt; overflow <= ovf_work; partial <= (bit_cnt != 0).
    - Clear pix_cnt, bit_cnt, ovf_work and the working buffer; go to IDLE.
- An edge cannot coincide with the timeout, because an edge clears idle_cnt. An edge arriving in the DONE cycle is held by the s3 comparison and processed in IDLE the next cycle; no bit is lost.
- Partial trailing bits are discarded (not emitted on pixel_v).
- rst mid-frame: all state clears immediately and no frame_done is issued. The previous rgb_frame is cleared to 0.

Test Plan:
- Single pixel: send 0xFF8001 MSB-first (half-period 4 clk), then 6250+ idle-low cycles -> one pixel_v with pixel_rgb=0xFF8001, pixel_idx=0. Exactly one frame_done with frame_leds=1, rgb_frame[23:0]=0xFF8001, rest 0, overflow=0, partial=0.
- Full frame: 50 pixels, pixel i = {i, 8'hA5, ~i}, then latch -> 50 pixel_v pulses with idx 0..49 in order, frame_leds=50, rgb_frame[24*49 +: 24]=0x31A5CE.
- Overflow: 52 pixels, then latch -> 52 pixel_v pulses (idx 49 repeated for the extra two), overflow=1, frame_leds=50, rgb_frame equal to the first 50 pixels.
- Partial/latch boundary: 2 pixels + 5 bits; gap of 6249 cycles, then further bits -> no frame_done at 6249. Later gap of 6250 -> frame_done, partial=1, trailing bits dropped.
- Reset corner: sClk held high through reset release -> no edge is counted until sClk goes low then high. rst asserted after 30 bits -> outputs 0, no frame_done, next frame decodes correctly from bit 0.
- Loopback: jumper the LED driver outputs to sClk/sIn with static visualiser data -> rgb_frame matches the driver's input frame on every frame_done, with no overflow and no partial.
